// File: rtl/pps_seconds_ctrl_pkg.sv
// Shared types and constants for the PPS-aligned seconds sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state encoding, counter widths, saturating tick increment helper.
package pps_ctrl_pkg;

  localparam int SEC_W  = 32;
  localparam int TICK_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Tick counter never wraps: a dead PPS must not make ticks look in-window again.
  function automatic logic [TICK_W-1:0] sat_inc(input logic [TICK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pps_seconds_ctrl_if.sv
// Control/status bundle between software-side logic and the seconds sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle strobes.
// Ports: master drives pps_in/arm/load_val and observes seconds/ticks/state/flags;
//        slave is the sequencer side.
interface pps_seconds_ctrl_if;
  import pps_ctrl_pkg::*;

  logic              pps_in;
  logic              arm;
  logic [SEC_W-1:0]  load_val;
  logic [SEC_W-1:0]  seconds;
  logic [TICK_W-1:0] ticks;
  logic [1:0]        state;
  logic              pps_missed;
  logic              pps_early;

  modport master (
    output pps_in, arm, load_val,
    input  seconds, ticks, state, pps_missed, pps_early
  );

  modport slave (
    input  pps_in, arm, load_val,
    output seconds, ticks, state, pps_missed, pps_early
  );

endinterface

// File: rtl/pps_seconds_ctrl_sync.sv
// 2-FF synchronizer plus rising-edge detect for an asynchronous strobe.
// Latency: evt is high in the 3rd clk cycle after async_in rises (2 sync flops, then edge compare).
// Backpressure: none; evt is a one-cycle pulse per rising edge.
// Ports: clk, rst_n (async active-low), async_in (raw), evt (one-cycle pulse, flop-derived).
module pps_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic evt
);

  logic sync0;
  logic sync1;
  logic sync1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      sync1_d <= 1'b0;
    end else begin
      sync0   <= async_in;
      sync1   <= sync0;
      sync1_d <= sync1;
    end
  end

  // Only flop outputs feed this gate, so it carries no path from async_in.
  assign evt = sync1 & ~sync1_d;

endmodule

// File: rtl/pps_seconds_ctrl.sv
// Seconds/tick sequencer aligned to external PPS under software arm control; flags early/missing edges.
// Latency: pps_in rise -> seconds/ticks update in 3 cycles; arm rise -> state ARMED in 2 cycles.
// Backpressure: none; edges are consumed or rejected in the cycle they are seen.
// Ports: user_clk, user_rst_n (async active-low), bus (slave: pps_in, arm, load_val in;
//        seconds, ticks, state, pps_missed, pps_early out, all registered).
// Build option: define PPS_HOLDOVER_EN to free-run seconds on a missing PPS instead of holding.
module pps_seconds_ctrl
  import pps_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 200000000,
  parameter int unsigned TOL           = 1024
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  pps_seconds_ctrl_if.slave  bus
);

  // Earliest tick count at which an edge is accepted as on-time.
  localparam logic [TICK_W-1:0] EARLY_LIM = TICK_W'(TICKS_PER_SEC - TOL);
  // Expiry is decided one cycle ahead so pps_missed rises together with
  // ticks reaching TICKS_PER_SEC+TOL, and a holdover second lasts exactly
  // TICKS_PER_SEC+TOL cycles.
  localparam logic [TICK_W-1:0] EXPIRE_PRE = TICK_W'(TICKS_PER_SEC + TOL - 1);

  logic              pps_evt;
  logic              arm_d;
  logic              arm_evt;
  state_e            state_q;
  logic [SEC_W-1:0]  seconds_q;
  logic [TICK_W-1:0] ticks_q;
  logic              missed_q;
  logic              early_q;

  pps_sync u_pps_sync (
    .clk      (user_clk),
    .rst_n    (user_rst_n),
    .async_in (bus.pps_in),
    .evt      (pps_evt)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      arm_d     <= 1'b0;
      arm_evt   <= 1'b0;
      state_q   <= IDLE;
      seconds_q <= '0;
      ticks_q   <= '0;
      missed_q  <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      arm_d   <= bus.arm;
      arm_evt <= bus.arm & ~arm_d;

      if (arm_evt) begin
        // Re-arm beats any coincident PPS edge; counters hold.
        state_q  <= ARMED;
        missed_q <= 1'b0;
        early_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
          end
          ARMED: begin
            if (pps_evt) begin
              seconds_q <= bus.load_val;
              ticks_q   <= '0;
              state_q   <= RUN;
            end
          end
          RUN: begin
            // Past expiry ticks keeps counting upward, so any later edge
            // lands above EARLY_LIM and is accepted unconditionally.
            if (pps_evt && (ticks_q >= EARLY_LIM)) begin
              seconds_q <= seconds_q + 1'b1;
              ticks_q   <= '0;
            end else begin
              if (pps_evt) begin
                early_q <= 1'b1;
              end
              if (ticks_q == EXPIRE_PRE) begin
                missed_q <= 1'b1;
`ifdef PPS_HOLDOVER_EN
                seconds_q <= seconds_q + 1'b1;
                ticks_q   <= '0;
`else
                ticks_q   <= sat_inc(ticks_q);
`endif
              end else begin
                ticks_q <= sat_inc(ticks_q);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.seconds    = seconds_q;
  assign bus.ticks      = ticks_q;
  assign bus.state      = state_q;
  assign bus.pps_missed = missed_q;
  assign bus.pps_early  = early_q;

endmodule

// File: tb/tb_pps_seconds_ctrl.sv
// Directed bench for pps_seconds_ctrl with TICKS_PER_SEC=100, TOL=4.
// Latency: n/a.
// Backpressure: n/a.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_pps_seconds_ctrl;

  logic user_clk = 1'b0;
  logic user_rst_n;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] exp_sec;

  pps_seconds_ctrl_if bus ();

  pps_seconds_ctrl #(
    .TICKS_PER_SEC (100),
    .TOL           (4)
  ) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .bus        (bus)
  );

  always #5 user_clk = ~user_clk;

  task automatic step(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Raise pps_in for two cycles; the counters update on the next edge.
  task automatic pulse_pps();
    bus.pps_in = 1'b1;
    step(2);
    bus.pps_in = 1'b0;
  endtask

  // From a known ticks value 'cur', deliver an edge evaluated when ticks == n,
  // then step to the cycle where its effect is visible.
  task automatic pps_when(input int cur, input int n);
    step(n - cur - 2);
    pulse_pps();
    step(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sec"},   bus.seconds, 32'h0);
    check({tag, "_ticks"}, bus.ticks, 32'h0);
    check({tag, "_state"}, {30'h0, bus.state}, 32'd0);
    check({tag, "_miss"},  {31'h0, bus.pps_missed}, 32'd0);
    check({tag, "_early"}, {31'h0, bus.pps_early}, 32'd0);
  endtask

  initial begin
    user_rst_n   = 1'b0;
    bus.pps_in   = 1'b0;
    bus.arm      = 1'b0;
    bus.load_val = 32'h0;
    step(3);
    check_reset_vals("rst");

    // Idle for 500 cycles, including a PPS that must be ignored.
    user_rst_n = 1'b1;
    step(200);
    pulse_pps();
    step(298);
    check_reset_vals("idle500");

    // Arm: ARMED 2 cycles after the rise.
    bus.load_val = 32'h1000;
    bus.arm      = 1'b1;
    step(1);
    check("arm_lat1", {30'h0, bus.state}, 32'd0);
    step(1);
    check("arm_lat2", {30'h0, bus.state}, 32'd1);
    bus.arm = 1'b0;
    step(5);
    check("armed_hold", bus.seconds, 32'h0);

    // First edge loads load_val after 3 cycles.
    bus.pps_in = 1'b1;
    step(2);
    check("load_lat2", bus.seconds, 32'h0);
    bus.pps_in = 1'b0;
    step(1);
    check("load_sec",   bus.seconds, 32'h1000);
    check("load_ticks", bus.ticks, 32'h0);
    check("load_state", {30'h0, bus.state}, 32'd2);

    // Nominal seconds.
    step(97);
    pulse_pps();
    check("pre_edge_ticks", bus.ticks, 32'd99);
    check("pre_edge_sec",   bus.seconds, 32'h1000);
    step(1);
    check("sec1", bus.seconds, 32'h1001);
    check("sec1_ticks", bus.ticks, 32'h0);
    pps_when(0, 100);
    check("sec2", bus.seconds, 32'h1002);
    check("sec2_ticks", bus.ticks, 32'h0);
    check("sec2_early", {31'h0, bus.pps_early}, 32'd0);

    // Early edge at 50 is rejected; the edge at 100 counts.
    pps_when(0, 50);
    check("early_flag",  {31'h0, bus.pps_early}, 32'd1);
    check("early_sec",   bus.seconds, 32'h1002);
    check("early_ticks", bus.ticks, 32'd51);
    pps_when(51, 100);
    check("after_early_sec",   bus.seconds, 32'h1003);
    check("after_early_ticks", bus.ticks, 32'h0);

    // Window boundaries: 96 accepted, 95 rejected.
    pps_when(0, 96);
    check("win96_sec", bus.seconds, 32'h1004);
    pps_when(0, 95);
    check("win95_sec",   bus.seconds, 32'h1004);
    check("win95_ticks", bus.ticks, 32'd96);
    pps_when(96, 98);
    check("win98_sec", bus.seconds, 32'h1005);
    check("miss_pre",  {31'h0, bus.pps_missed}, 32'd0);

    // PPS withheld.
    step(103);
    check("miss_103_ticks", bus.ticks, 32'd103);
    check("miss_103_flag",  {31'h0, bus.pps_missed}, 32'd0);
    step(1);
    check("miss_flag", {31'h0, bus.pps_missed}, 32'd1);
`ifdef PPS_HOLDOVER_EN
    check("hold_sec1",   bus.seconds, 32'h1006);
    check("hold_ticks1", bus.ticks, 32'h0);
    step(104);
    check("hold_sec2",   bus.seconds, 32'h1007);
    check("hold_ticks2", bus.ticks, 32'h0);
    pps_when(0, 100);
    exp_sec = 32'h1008;
`else
    check("nohold_sec",   bus.seconds, 32'h1005);
    check("nohold_ticks", bus.ticks, 32'd104);
    step(50);
    check("nohold_sec_late", bus.seconds, 32'h1005);
    pps_when(154, 160);
    exp_sec = 32'h1006;
`endif
    check("realign_sec",   bus.seconds, exp_sec);
    check("realign_ticks", bus.ticks, 32'h0);

    // arm_evt and pps_evt in the same cycle: arm wins, no increment.
    bus.load_val = 32'hFFFF_FFFF;
    step(97);
    bus.pps_in = 1'b1;
    step(1);
    bus.arm = 1'b1;
    step(1);
    bus.pps_in = 1'b0;
    step(1);
    check("coinc_state", {30'h0, bus.state}, 32'd1);
    check("coinc_sec",   bus.seconds, exp_sec);
    check("coinc_miss",  {31'h0, bus.pps_missed}, 32'd0);
    check("coinc_early", {31'h0, bus.pps_early}, 32'd0);
    bus.arm = 1'b0;
    step(10);
    pulse_pps();
    step(1);
    check("reload_sec",   bus.seconds, 32'hFFFF_FFFF);
    check("reload_state", {30'h0, bus.state}, 32'd2);

    // Seconds wraps without flags.
    pps_when(0, 100);
    check("wrap_sec",   bus.seconds, 32'h0);
    check("wrap_ticks", bus.ticks, 32'h0);
    check("wrap_miss",  {31'h0, bus.pps_missed}, 32'd0);
    check("wrap_early", {31'h0, bus.pps_early}, 32'd0);

    // Asynchronous reset mid-RUN.
    step(30);
    check("prerst_ticks", bus.ticks, 32'd30);
    user_rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    step(2);
    user_rst_n = 1'b1;
    step(2);
    pulse_pps();
    step(5);
    check_reset_vals("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pps_seconds_ctrl.md
# pps_seconds_ctrl

Sequencer for the design's seconds timestamp, the value software reads through the seconds simulink2ppc OPB register. Aligns a 32-bit seconds counter and a sub-second tick counter to the external PPS under software arm control. Flags early and missing PPS edges. Sits in the user_clk domain; its `seconds` output drives the register's `user_data_in`.

## Interface
- `TICKS_PER_SEC`, default 200000000: user_clk cycles per nominal second.
- `TOL`, default 1024: allowed PPS jitter window in ticks, ± around `TICKS_PER_SEC`.
- `user_clk` input 1: the single clock.
- `user_rst_n` input 1: reset, asynchronous, active-low.
- `pps_in` input 1: raw PPS from the board, asynchronous.
- `arm` input 1: software control bit, already in the user_clk domain.
- `load_val` input 32: seconds value loaded on the first PPS after arm.
- `seconds` output 32: current seconds; feeds the OPB register `user_data_in`.
- `ticks` output 32: cycles since the last accepted second boundary.
- `state` output 2: 0 IDLE, 1 ARMED, 2 RUN.
- `pps_missed` output 1: sticky flag, a PPS window expired without an edge.
- `pps_early` output 1: sticky flag, an edge was rejected as early.

## Operation
- `pps_in` passes through a 2-FF synchronizer, then a rising-edge detect; the result is `pps_evt`, one cycle wide.
- `arm_evt` is the rising edge of `arm`, registered.
- Behaviour in any state:
  - `arm_evt` → ARMED.
  - `arm_evt` clears `pps_missed` and `pps_early`.
  - `seconds` holds its value.
- IDLE (reset state):
  - counters frozen.
  - `pps_evt` ignored.
- ARMED:
  - `ticks` frozen.
  - On `pps_evt` (without `arm_evt` in the same cycle): `seconds` ← `load_val`, `ticks` ← 0, go to RUN.
- RUN:
  - `ticks` increments every cycle.
  - `pps_evt` with `ticks` ≥ `TICKS_PER_SEC`−`TOL`: `seconds`+1, `ticks` ← 0.
  - `pps_evt` with `ticks` < `TICKS_PER_SEC`−`TOL`: edge rejected, `pps_early` ← 1, `ticks` continues counting.
  - `ticks` = `TICKS_PER_SEC`+`TOL` with no edge: `pps_missed` ← 1, then the holdover behaviour under Configuration.
- Arithmetic:
  - `seconds` wraps modulo 2^32; 0xFFFFFFFF+1 → 0, no flag.
  - `ticks` saturates at 0xFFFFFFFF.
- Simultaneous events:
  - `arm_evt` wins over `pps_evt`; the edge is discarded and the state becomes ARMED.
  - `pps_evt` in the same cycle as the window expiry counts as an on-time edge; `pps_missed` is not set.

## Timing
- Reset values of all outputs: `seconds`=0, `ticks`=0, `state`=IDLE, `pps_missed`=0, `pps_early`=0.
- `pps_in` rising edge to updated `seconds`/`ticks`: 3 cycles (2 synchronizer flops + 1 update flop).
- `arm` rising edge to `state`=ARMED: 2 cycles.
- All outputs are registered; no combinational path from input to output.
- Reset asserted mid-RUN: everything returns to reset values immediately. Software must re-arm after release.

## Configuration
- `PPS_HOLDOVER_EN` defined:
  - On window expiry, `seconds`+1 and `ticks` ← 0; the block free-runs at the nominal rate.
  - The next in-window edge re-aligns the counters.
- `PPS_HOLDOVER_EN` undefined:
  - On window expiry, `seconds` holds and `ticks` saturates.
  - The next `pps_evt` is accepted unconditionally: `seconds`+1, `ticks` ← 0.

## Structure
- Package `pps_ctrl_pkg`:
  - state encoding constants IDLE/ARMED/RUN.
  - width constants SEC_W=32, TICK_W=32.
- Sub-module `pps_sync`: 2-FF synchronizer + rising-edge detect. Reused for any other asynchronous strobe in the design.

## Test plan
All scenarios use `TICKS_PER_SEC`=100, `TOL`=4.
- Reset, then no stimulus → `seconds`=0, `state`=0, both flags 0 for 500 cycles.
- Arm with `load_val`=0x1000, then PPS every 100 cycles → `seconds`=0x1000 3 cycles after the first edge, then 0x1001, 0x1002; `ticks` wraps to 0 after each edge.
- PPS at 50 cycles after an accepted edge → `pps_early`=1, `seconds` unchanged. The edge at 100 increments `seconds`.
- PPS withheld in RUN:
  - `pps_missed`=1 at `ticks`=104.
  - With `PPS_HOLDOVER_EN`: `seconds`+1 every 104 cycles.
  - Without it: `seconds` holds until the next edge.
- `arm` rising in the same cycle as `pps_evt` → `state`=ARMED, no load; the next PPS loads `load_val`. `seconds`=0xFFFFFFFF plus an on-time edge → 0.
- `user_rst_n` pulsed low mid-RUN → all outputs at reset values within the cycle; PPS ignored until re-arm.
